// File: rtl/instruction_fetch_sequencer.sv
// Fetch front end: owns the PC, drives the combinational instruction memory and
// registers the returned word into IF/ID with stall, redirect, halt and fault control.
module instruction_fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter int          IMEM_DEPTH = 128,
    parameter logic [31:0] HALT_WORD  = 32'h00000008
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    input  logic        Resume,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PCPlus4,
    output logic        IF_Valid,
    output logic        Halted,
    output logic        Fault,
    output logic [31:0] InstrCount
);

    localparam logic [31:0] IMEM_BYTES = 32'(4 * IMEM_DEPTH);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pcPlus4_q;
    logic        valid_q;
    logic        halted_q;
    logic        fault_q;
    logic [31:0] count_q;

    logic [31:0] pcPlus4_d;
    logic [31:0] count_d;
    logic        addrFault_d;

    // Wrap past the top of memory lands in the out-of-range check below.
    assign pcPlus4_d   = pc_q + 32'd4;
    assign count_d     = count_q + 32'd1;
    assign addrFault_d = (pc_q[1:0] != 2'b00) || (pc_q >= IMEM_BYTES);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            pcPlus4_q <= 32'd0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
            count_q   <= 32'd0;
        end else begin
            case (state_q)
                BOOT: begin
                    valid_q <= 1'b0;
                    state_q <= RUN;
                end
                RUN: begin
                    if (RedirectValid) begin
                        pc_q    <= RedirectTarget;
                        instr_q <= 32'd0;
                        valid_q <= 1'b0;
                    end else if (Stall) begin
                        pc_q    <= pc_q;
                    end else if (addrFault_d) begin
                        fault_q <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= HALT;
                    end else begin
                        instr_q   <= ImemInstruction;
                        pcPlus4_q <= pcPlus4_d;
                        valid_q   <= 1'b1;
                        pc_q      <= pcPlus4_d;
                        count_q   <= count_d;
                        // The halt word itself still issues once before fetch stops.
                        if (ImemInstruction == HALT_WORD) begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end
                    end
                end
                HALT: begin
                    valid_q <= 1'b0;
                    if (Resume) begin
                        halted_q <= 1'b0;
                        fault_q  <= 1'b0;
                        state_q  <= RUN;
                        if (RedirectValid) begin
                            pc_q <= RedirectTarget;
                        end
                    end
                end
                default: begin
                    state_q <= BOOT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ImemAddress    = pc_q;
    assign IF_Instruction = instr_q;
    assign IF_PCPlus4     = pcPlus4_q;
    assign IF_Valid       = valid_q;
    assign Halted         = halted_q;
    assign Fault          = fault_q;
    assign InstrCount     = count_q;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for the fetch sequencer: a combinational memory model plus
// per-scenario tasks with hand-computed expectations.
module tb_instruction_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        RedirectValid;
    logic [31:0] RedirectTarget;
    logic        Resume;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PCPlus4;
    logic        IF_Valid;
    logic        Halted;
    logic        Fault;
    logic [31:0] InstrCount;

    logic [31:0] mem [0:127];
    int vectors = 0;
    int miscompares = 0;

    instruction_fetch_sequencer dut (
        .Clk(Clk),
        .Reset(Reset),
        .Stall(Stall),
        .RedirectValid(RedirectValid),
        .RedirectTarget(RedirectTarget),
        .Resume(Resume),
        .ImemAddress(ImemAddress),
        .ImemInstruction(ImemInstruction),
        .IF_Instruction(IF_Instruction),
        .IF_PCPlus4(IF_PCPlus4),
        .IF_Valid(IF_Valid),
        .Halted(Halted),
        .Fault(Fault),
        .InstrCount(InstrCount)
    );

    always #5 Clk = ~Clk;

    assign ImemInstruction = mem[ImemAddress[8:2]];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Stall = 1'b0;
        RedirectValid = 1'b0;
        RedirectTarget = 32'd0;
        Resume = 1'b0;
        #12;
        vectors++;
        if ({IF_Instruction, IF_PCPlus4, IF_Valid, Halted, Fault, InstrCount, ImemAddress} !== {32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_state: instr=%h pc4=%h v=%b h=%b f=%b cnt=%0d addr=%h, want all zero",
                     IF_Instruction, IF_PCPlus4, IF_Valid, Halted, Fault, InstrCount, ImemAddress);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        words[0] = 32'h34040000;
        words[1] = 32'h08000004;
        words[2] = 32'h20040000;
        tick();
        vectors++;
        if ({IF_Valid, ImemAddress} !== {1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL boot_cycle: valid=%b addr=%h, want 0 / 00000000", IF_Valid, ImemAddress);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({IF_Valid, IF_Instruction, IF_PCPlus4} !== {1'b1, words[i], 32'(4 * (i + 1))}) begin
                miscompares++;
                $display("FAIL seq_issue%0d: valid=%b instr=%h pc4=%h, want 1 %h %h",
                         i, IF_Valid, IF_Instruction, IF_PCPlus4, words[i], 32'(4 * (i + 1)));
            end
        end
        vectors++;
        if ({InstrCount, ImemAddress} !== {32'd3, 32'h0C}) begin
            miscompares++;
            $display("FAIL seq_count: cnt=%0d addr=%h, want 3 0000000c", InstrCount, ImemAddress);
        end
    endtask

    task automatic test_stall();
        tick();
        Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({ImemAddress, IF_Instruction, IF_Valid, IF_PCPlus4} !== {32'h10, mem[3], 1'b1, 32'h10}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: addr=%h instr=%h v=%b pc4=%h, want 00000010 %h 1 00000010",
                         i, ImemAddress, IF_Instruction, IF_Valid, IF_PCPlus4, mem[3]);
            end
        end
        Stall = 1'b0;
        tick();
        vectors++;
        if ({IF_Instruction, IF_PCPlus4, ImemAddress, InstrCount} !== {mem[4], 32'h14, 32'h14, 32'd5}) begin
            miscompares++;
            $display("FAIL stall_release: instr=%h pc4=%h addr=%h cnt=%0d, want %h 00000014 00000014 5",
                     IF_Instruction, IF_PCPlus4, ImemAddress, InstrCount, mem[4]);
        end
    endtask

    task automatic test_redirect_over_stall();
        RedirectValid = 1'b1;
        RedirectTarget = 32'h10;
        Stall = 1'b1;
        tick();
        RedirectValid = 1'b0;
        Stall = 1'b0;
        vectors++;
        if ({ImemAddress, IF_Valid, IF_Instruction} !== {32'h10, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL redirect_bubble: addr=%h v=%b instr=%h, want 00000010 0 00000000",
                     ImemAddress, IF_Valid, IF_Instruction);
        end
        tick();
        vectors++;
        if ({IF_Valid, IF_Instruction, IF_PCPlus4, InstrCount} !== {1'b1, mem[4], 32'h14, 32'd6}) begin
            miscompares++;
            $display("FAIL redirect_issue: v=%b instr=%h pc4=%h cnt=%0d, want 1 %h 00000014 6",
                     IF_Valid, IF_Instruction, IF_PCPlus4, InstrCount, mem[4]);
        end
    endtask

    task automatic test_halt();
        RedirectValid = 1'b1;
        RedirectTarget = 32'hD4;
        tick();
        RedirectValid = 1'b0;
        tick();
        vectors++;
        if ({IF_Valid, IF_Instruction, IF_PCPlus4, Halted, ImemAddress, InstrCount} !== {1'b1, 32'h8, 32'hD8, 1'b1, 32'hD8, 32'd7}) begin
            miscompares++;
            $display("FAIL halt_issue: v=%b instr=%h pc4=%h h=%b addr=%h cnt=%0d, want 1 00000008 000000d8 1 000000d8 7",
                     IF_Valid, IF_Instruction, IF_PCPlus4, Halted, ImemAddress, InstrCount);
        end
        RedirectValid = 1'b1;
        RedirectTarget = 32'h40;
        tick();
        RedirectValid = 1'b0;
        vectors++;
        if ({IF_Valid, Halted, ImemAddress, IF_Instruction, InstrCount} !== {1'b0, 1'b1, 32'hD8, 32'h8, 32'd7}) begin
            miscompares++;
            $display("FAIL halt_hold: v=%b h=%b addr=%h instr=%h cnt=%0d, want 0 1 000000d8 00000008 7",
                     IF_Valid, Halted, ImemAddress, IF_Instruction, InstrCount);
        end
        Resume = 1'b1;
        tick();
        Resume = 1'b0;
        vectors++;
        if ({Halted, IF_Valid, ImemAddress} !== {1'b0, 1'b0, 32'hD8}) begin
            miscompares++;
            $display("FAIL halt_resume: h=%b v=%b addr=%h, want 0 0 000000d8", Halted, IF_Valid, ImemAddress);
        end
        tick();
        vectors++;
        if ({IF_Valid, IF_Instruction, IF_PCPlus4, InstrCount} !== {1'b1, mem[54], 32'hDC, 32'd8}) begin
            miscompares++;
            $display("FAIL halt_continue: v=%b instr=%h pc4=%h cnt=%0d, want 1 %h 000000dc 8",
                     IF_Valid, IF_Instruction, IF_PCPlus4, InstrCount, mem[54]);
        end
    endtask

    task automatic test_fault();
        RedirectValid = 1'b1;
        RedirectTarget = 32'h202;
        tick();
        RedirectValid = 1'b0;
        tick();
        vectors++;
        if ({Fault, IF_Valid, ImemAddress, Halted} !== {1'b1, 1'b0, 32'h202, 1'b0}) begin
            miscompares++;
            $display("FAIL fault_misaligned: f=%b v=%b addr=%h h=%b, want 1 0 00000202 0", Fault, IF_Valid, ImemAddress, Halted);
        end
        Resume = 1'b1;
        tick();
        Resume = 1'b0;
        tick();
        vectors++;
        if ({Fault, ImemAddress} !== {1'b1, 32'h202}) begin
            miscompares++;
            $display("FAIL fault_refault: f=%b addr=%h, want 1 00000202", Fault, ImemAddress);
        end
        Resume = 1'b1;
        RedirectValid = 1'b1;
        RedirectTarget = 32'h10;
        tick();
        Resume = 1'b0;
        RedirectValid = 1'b0;
        vectors++;
        if ({Fault, ImemAddress, IF_Valid} !== {1'b0, 32'h10, 1'b0}) begin
            miscompares++;
            $display("FAIL fault_resume: f=%b addr=%h v=%b, want 0 00000010 0", Fault, ImemAddress, IF_Valid);
        end
        tick();
        vectors++;
        if ({IF_Valid, IF_Instruction, InstrCount} !== {1'b1, mem[4], 32'd9}) begin
            miscompares++;
            $display("FAIL fault_refetch: v=%b instr=%h cnt=%0d, want 1 %h 9", IF_Valid, IF_Instruction, InstrCount, mem[4]);
        end
        RedirectValid = 1'b1;
        RedirectTarget = 32'h1FC;
        tick();
        RedirectValid = 1'b0;
        tick();
        vectors++;
        if ({IF_Valid, IF_Instruction, IF_PCPlus4, Fault, ImemAddress, InstrCount} !== {1'b1, mem[127], 32'h200, 1'b0, 32'h200, 32'd10}) begin
            miscompares++;
            $display("FAIL fault_last_word: v=%b instr=%h pc4=%h f=%b addr=%h cnt=%0d, want 1 %h 00000200 0 00000200 10",
                     IF_Valid, IF_Instruction, IF_PCPlus4, Fault, ImemAddress, InstrCount, mem[127]);
        end
        tick();
        vectors++;
        if ({Fault, IF_Valid, ImemAddress, InstrCount} !== {1'b1, 1'b0, 32'h200, 32'd10}) begin
            miscompares++;
            $display("FAIL fault_range: f=%b v=%b addr=%h cnt=%0d, want 1 0 00000200 10", Fault, IF_Valid, ImemAddress, InstrCount);
        end
    endtask

    task automatic test_async_reset();
        #2;
        Reset = 1'b1;
        #1;
        vectors++;
        if ({IF_Instruction, IF_PCPlus4, IF_Valid, Halted, Fault, InstrCount, ImemAddress} !== {32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL async_reset: instr=%h pc4=%h v=%b h=%b f=%b cnt=%0d addr=%h, want all zero",
                     IF_Instruction, IF_PCPlus4, IF_Valid, Halted, Fault, InstrCount, ImemAddress);
        end
        tick();
        Reset = 1'b0;
        tick();
        tick();
        vectors++;
        if ({IF_Valid, IF_Instruction, InstrCount} !== {1'b1, 32'h34040000, 32'd1}) begin
            miscompares++;
            $display("FAIL after_reset_issue: v=%b instr=%h cnt=%0d, want 1 34040000 1", IF_Valid, IF_Instruction, InstrCount);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = 32'h10000000 + 32'(i);
        end
        mem[0]  = 32'h34040000;
        mem[1]  = 32'h08000004;
        mem[2]  = 32'h20040000;
        mem[53] = 32'h00000008;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_over_stall();
        test_halt();
        test_fault();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
